rr_decod_arbiter: RTL and testbench

- Round-robin arbiter sharing one 3-to-8 one-hot select resource between 8 requesters.
- Produces the encoded select index and the enable that drive the decoder, plus a registered one-hot grant vector.
- Grants are held across multiple cycles until released, or until a hold-limit forces rotation.
- Sits between the requesting units and the one-hot decoder, as its sole sequencer.

---
 rtl/rr_decod_arbiter.sv | 144 ++++++++++++++
 tb/tb_rr_decod_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_decod_arbiter.sv
// rr_decod_arbiter
//   Round-robin arbiter that owns a shared 3-to-8 one-hot decoder on behalf
//   of eight requesters. A winner keeps the grant until it signals done,
//   drops its request, or exhausts the hold limit. Every release is followed
//   by at least one idle cycle, so the decoder output is all-zero between
//   owners.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      level-sensitive requests, bit i = requester i
//   done     current owner releases the resource (ignored outside GRANT)
//   gnt_idx  registered index of the current owner (decoder select)
//   gnt_en   registered, high while a grant is active (decoder enable)
//   gnt      registered one-hot grant, 1<<gnt_idx when gnt_en else 0
//   busy     registered, identical to gnt_en
//
// Parameters
//   HOLD_MAX maximum consecutive GRANT cycles per owner, 0 = unlimited
//   CW       hold counter width, 2**CW must exceed HOLD_MAX

module rr_decod_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_en,
  output logic [7:0] gnt,
  output logic       busy
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_GRANT = 1'b1;

  localparam int unsigned   HOLD_LAST_I = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_LAST_I);
  localparam logic          HOLD_EN     = (HOLD_MAX != 0);

  logic          r_state;
  logic [2:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          r_en;
  logic [7:0]    r_gnt;

  logic          w_state_nx;
  logic [2:0]    w_ptr_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [2:0]    w_idx_nx;
  logic          w_en_nx;
  logic [7:0]    w_gnt_nx;

  logic          w_found;
  logic [2:0]    w_sel;
  logic [2:0]    w_cand;
  logic          w_hold_hit;
  logic          w_release;

  // Circular scan starting at r_ptr; the first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_cand  = r_ptr;
    for (int unsigned i = 0; i < 8; i++) begin
      w_cand = r_ptr + 3'(i);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // Only the owner's own request line is observed while granted; done and a
  // withdrawn request on the same edge collapse into one release.
  always_comb begin
    w_hold_hit = HOLD_EN && (r_cnt == HOLD_LAST);
    w_release  = done || !req[r_idx] || w_hold_hit;
  end

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_en_nx    = r_en;
    w_gnt_nx   = r_gnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx = S_GRANT;
          w_idx_nx   = w_sel;
          w_en_nx    = 1'b1;
          w_gnt_nx   = 8'(1) << w_sel;
          w_cnt_nx   = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          // gnt_idx is left as-is; it is a don't-care once gnt_en drops.
          w_state_nx = S_IDLE;
          w_en_nx    = 1'b0;
          w_gnt_nx   = '0;
          w_ptr_nx   = r_idx + 3'd1;
          w_cnt_nx   = '0;
        end else if (r_cnt != '1) begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_en_nx    = 1'b0;
        w_gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_en    <= 1'b0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_en    <= w_en_nx;
      r_gnt   <= w_gnt_nx;
    end
  end

  assign gnt_idx = r_idx;
  assign gnt_en  = r_en;
  assign gnt     = r_gnt;
  assign busy    = r_en;

endmodule

// File: tb/tb_rr_decod_arbiter.sv
// tb_rr_decod_arbiter
//   Directed bench for rr_decod_arbiter built with HOLD_MAX=4 so the hold
//   limit is reachable in a few cycles. Expected values are hand-derived
//   from the arbitration rules; output invariants are also checked on every
//   falling clock edge.

module tb_rr_decod_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_en;
  logic [7:0] gnt;
  logic       busy;

  int n_checks;
  int n_fail;
  logic [7:0] inv_exp;

  rr_decod_arbiter #(
    .HOLD_MAX (4),
    .CW       (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_en  (gnt_en),
    .gnt     (gnt),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Output invariants, sampled away from the active edge.
  always @(negedge clk) begin
    inv_exp = gnt_en ? (8'(1) << gnt_idx) : 8'h00;
    chk("inv_onehot", {7'd0, ($countones(gnt) <= 1)}, 8'h01);
    chk("inv_gnt_vs_idx", gnt, inv_exp);
    chk("inv_busy", {7'd0, busy}, {7'd0, gnt_en});
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 8'h00;
    done     = 1'b0;

    // Power-on reset
    #2;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_en", {7'd0, gnt_en}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_idx", {5'd0, gnt_idx}, 8'h00);
    tick;
    tick;
    rst_n = 1'b1;

    // Idle with no requests, done ignored in IDLE
    done = 1'b1;
    tick;
    chk("idle_noreq_en", {7'd0, gnt_en}, 8'h00);
    done = 1'b0;

    // Single requester 3: three grant cycles, done in the third
    req = 8'h08;
    tick;
    chk("single_g1", gnt, 8'h08);
    chk("single_idx", {5'd0, gnt_idx}, 8'h03);
    tick;
    chk("single_g2", gnt, 8'h08);
    tick;
    chk("single_g3", gnt, 8'h08);
    done = 1'b1;
    tick;
    chk("single_dead_gnt", gnt, 8'h00);
    chk("single_dead_en", {7'd0, gnt_en}, 8'h00);
    done = 1'b0;
    tick;
    chk("single_regrant", gnt, 8'h08);
    req = 8'h00;
    tick;
    chk("single_withdraw", {7'd0, gnt_en}, 8'h00);

    // Reset mid-grant (ptr=4, req[2] -> idx 2), then restart from ptr=0
    req = 8'h04;
    tick;
    chk("mid_grant", gnt, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 8'h00);
    chk("async_rst_en", {7'd0, gnt_en}, 8'h00);
    chk("async_rst_busy", {7'd0, busy}, 8'h00);
    req = 8'h81;
    #2;
    rst_n = 1'b1;
    tick;
    chk("post_rst_gnt", gnt, 8'h01);
    chk("post_rst_idx", {5'd0, gnt_idx}, 8'h00);

    // Round-robin with all requesting, done every second grant cycle
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      chk("rr_grant", gnt, 8'(1) << (k % 8));
      done = 1'b0;
      tick;
      chk("rr_hold", gnt, 8'(1) << (k % 8));
      done = 1'b1;
      tick;
      chk("rr_dead", {7'd0, gnt_en}, 8'h00);
      done = 1'b0;
      tick;
    end
    chk("rr_after", gnt, 8'h02);

    // Wrap/pointer: owner 1 withdraws, ptr=2, then idx 6 wins
    req = 8'h40;
    tick;
    chk("wrap_rel1", {7'd0, gnt_en}, 8'h00);
    tick;
    chk("wrap_g6", gnt, 8'h40);
    done = 1'b1;
    tick;
    chk("wrap_rel6", {7'd0, gnt_en}, 8'h00);
    done = 1'b0;
    req  = 8'h41;
    tick;
    chk("wrap_ptr7_g0", gnt, 8'h01);
    done = 1'b1;
    tick;
    chk("wrap_rel0", {7'd0, gnt_en}, 8'h00);
    done = 1'b0;
    tick;
    chk("wrap_ptr1_g6", gnt, 8'h40);
    chk("wrap_idx6", {5'd0, gnt_idx}, 8'h06);
    done = 1'b1;
    req  = 8'h00;
    tick;
    chk("wrap_final_rel", {7'd0, gnt_en}, 8'h00);
    done = 1'b0;

    // Hold limit 4: ptr=7, req 4 and 5 held
    req = 8'h30;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("hold_a4", gnt, 8'h10);
      tick;
    end
    chk("hold_dead1", gnt, 8'h00);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("hold_b5", gnt, 8'h20);
      tick;
    end
    chk("hold_dead2", gnt, 8'h00);
    tick;
    chk("hold_back4", gnt, 8'h10);
    req = 8'h00;
    tick;
    chk("hold_withdraw", {7'd0, gnt_en}, 8'h00);

    // Withdraw and done collide: ptr=5, owner 2, then req 1|2 -> idx 1
    req = 8'h04;
    tick;
    chk("coll_g2", gnt, 8'h04);
    req  = 8'h00;
    done = 1'b1;
    tick;
    chk("coll_rel", {7'd0, gnt_en}, 8'h00);
    done = 1'b0;
    req  = 8'h06;
    tick;
    chk("coll_g1", gnt, 8'h02);
    chk("coll_idx1", {5'd0, gnt_idx}, 8'h01);
    req = 8'h00;
    tick;
    chk("coll_withdraw", {7'd0, gnt_en}, 8'h00);

    // done high in IDLE does not block a new grant (ptr=2, req 3)
    done = 1'b1;
    req  = 8'h08;
    tick;
    chk("idle_done_grant", gnt, 8'h08);
    tick;
    chk("idle_done_then_rel", {7'd0, gnt_en}, 8'h00);
    done = 1'b0;
    req  = 8'h00;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
